// File: rtl/ycbcr_pkg.sv
// Shared constants for the UYVY -> RGB565 converter: phase encoding, latency, coefficients.
// YCBCR_LIMITED_RANGE_EN selects BT.601 limited range; otherwise the full-range (JFIF) set.
package ycbcr_pkg;
  typedef logic signed [18:0] prod_t;
  typedef logic signed [19:0] sum_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycc_t;

  localparam logic [1:0] ST_CB = 2'd0;
  localparam logic [1:0] ST_Y0 = 2'd1;
  localparam logic [1:0] ST_CR = 2'd2;
  localparam logic [1:0] ST_Y1 = 2'd3;

  localparam int LATENCY = 4;

`ifdef YCBCR_LIMITED_RANGE_EN
  localparam prod_t Y_OFF = 19'sd16;
  localparam prod_t Y_MUL = 19'sd298;
  localparam prod_t KR    = 19'sd409;
  localparam prod_t KGB   = 19'sd100;
  localparam prod_t KGR   = 19'sd208;
  localparam prod_t KB    = 19'sd516;
`else
  localparam prod_t Y_OFF = 19'sd0;
  localparam prod_t Y_MUL = 19'sd256;
  localparam prod_t KR    = 19'sd359;
  localparam prod_t KGB   = 19'sd88;
  localparam prod_t KGR   = 19'sd183;
  localparam prod_t KB    = 19'sd454;
`endif

  function automatic logic [7:0] clamp8(input logic signed [11:0] v);
    logic [7:0] res;
    if (v[11])             res = 8'd0;
    else if (v > 12'sd255) res = 8'hFF;
    else                   res = v[7:0];
    return res;
  endfunction
endpackage

// File: rtl/ycbcr422_rgb565_if.sv
// Pixel stream bus: camera-side pre_* in, display-side post_* out.
interface ycbcr422_rgb565_if;
  logic [7:0]  pre_imgdata;
  logic        pre_clken;
  logic        pre_hs;
  logic        pre_vs;
  logic [15:0] post_imgdata;
  logic        post_clken;
  logic        post_hs;
  logic        post_vs;

  modport master (
    output pre_imgdata, pre_clken, pre_hs, pre_vs,
    input  post_imgdata, post_clken, post_hs, post_vs
  );
  modport slave (
    input  pre_imgdata, pre_clken, pre_hs, pre_vs,
    output post_imgdata, post_clken, post_hs, post_vs
  );
endinterface

// File: rtl/ycbcr_rgb_core.sv
// Per-pixel E1..E3 pipeline: products, rounded sums, clamp + RGB565 pack.
// Coefficients come from ycbcr_pkg (YCBCR_LIMITED_RANGE_EN picks the set).
module ycbcr_rgb_core import ycbcr_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vld,
  input  ycc_t        i_pix,
  output logic        o_vld,
  output logic [15:0] o_rgb
);
  logic [3:1]        r_vld_pipe;
  logic signed [8:0] w_dcb, w_dcr;
  prod_t             w_y;
  prod_t             r_ys, r_pr, r_pgb, r_pgr, r_pb;
  sum_t              w_r, w_g, w_b;
  logic signed [11:0] r_r, r_g, r_b;
  logic [7:0]        w_rc, w_gc, w_bc;
  logic [15:0]       r_rgb;

  assign w_dcb = $signed({1'b0, i_pix.cb}) - 9'sd128;
  assign w_dcr = $signed({1'b0, i_pix.cr}) - 9'sd128;
  assign w_y   = $signed({11'd0, i_pix.y});

  // Sums carry the +128 rounding term; upper 12 bits are the >>>8 result.
  assign w_r = sum_t'(r_ys) + sum_t'(r_pr) + 20'sd128;
  assign w_g = sum_t'(r_ys) - sum_t'(r_pgb) - sum_t'(r_pgr) + 20'sd128;
  assign w_b = sum_t'(r_ys) + sum_t'(r_pb) + 20'sd128;

  assign w_rc = clamp8(r_r);
  assign w_gc = clamp8(r_g);
  assign w_bc = clamp8(r_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_ys <= '0; r_pr <= '0; r_pgb <= '0; r_pgr <= '0; r_pb <= '0;
      r_r  <= '0; r_g  <= '0; r_b   <= '0;
      r_rgb <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[2:1], i_vld};
      r_ys  <= (w_y - Y_OFF) * Y_MUL;
      r_pr  <= prod_t'(w_dcr) * KR;
      r_pgb <= prod_t'(w_dcb) * KGB;
      r_pgr <= prod_t'(w_dcr) * KGR;
      r_pb  <= prod_t'(w_dcb) * KB;
      r_r   <= w_r[19:8];
      r_g   <= w_g[19:8];
      r_b   <= w_b[19:8];
      if (r_vld_pipe[2]) r_rgb <= {w_rc[7:3], w_gc[7:2], w_bc[7:3]};
    end
  end

  assign o_vld = r_vld_pipe[3];
  assign o_rgb = r_rgb;
endmodule

// File: rtl/ycbcr422_rgb565.sv
// UYVY byte stream -> RGB565 pixel stream with hs/vs carried through a 4-cycle delay.
// Colour range set by YCBCR_LIMITED_RANGE_EN (see ycbcr_pkg).
module ycbcr422_rgb565 import ycbcr_pkg::*; (
  input logic             clk,
  input logic             rst,
  ycbcr422_rgb565_if.slave bus
);
  logic [1:0]         r_state;
  logic [7:0]         r_cb_h, r_y0_h, r_cr_h;
  logic               r_trig;
  ycc_t               r_pix;
  logic [LATENCY-1:0] r_hs_pipe, r_vs_pipe;
  logic               w_vld;
  logic [15:0]        w_rgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CB;
      r_cb_h    <= '0;
      r_y0_h    <= '0;
      r_cr_h    <= '0;
      r_trig    <= 1'b0;
      r_pix     <= '0;
      r_hs_pipe <= '0;
      r_vs_pipe <= '0;
    end else begin
      r_trig    <= 1'b0;
      r_hs_pipe <= {r_hs_pipe[LATENCY-2:0], bus.pre_hs};
      r_vs_pipe <= {r_vs_pipe[LATENCY-2:0], bus.pre_vs};
      // Outside the active line the phase is pinned so each line opens on Cb.
      if (!bus.pre_hs) begin
        r_state <= ST_CB;
      end else if (bus.pre_clken) begin
        r_state <= r_state + 2'd1;
        case (r_state)
          ST_CB: r_cb_h <= bus.pre_imgdata;
          ST_Y0: r_y0_h <= bus.pre_imgdata;
          ST_CR: begin
            r_cr_h <= bus.pre_imgdata;
            r_trig <= 1'b1;
            r_pix  <= '{y: r_y0_h, cb: r_cb_h, cr: bus.pre_imgdata};
          end
          ST_Y1: begin
            r_trig <= 1'b1;
            r_pix  <= '{y: bus.pre_imgdata, cb: r_cb_h, cr: r_cr_h};
          end
          default: ;
        endcase
      end
    end
  end

  ycbcr_rgb_core u_core (
    .clk   (clk),
    .rst   (rst),
    .i_vld (r_trig),
    .i_pix (r_pix),
    .o_vld (w_vld),
    .o_rgb (w_rgb)
  );

  assign bus.post_clken   = w_vld;
  assign bus.post_imgdata = w_rgb;
  assign bus.post_hs      = r_hs_pipe[LATENCY-1];
  assign bus.post_vs      = r_vs_pipe[LATENCY-1];
endmodule

// File: tb/tb_ycbcr422_rgb565.sv
// Bench for ycbcr422_rgb565: vector table, directed line/reset sequences, random stream
// against a cycle-indexed arithmetic reference.
`timescale 1ns/1ps
module tb_ycbcr422_rgb565;
`ifdef YCBCR_LIMITED_RANGE_EN
  localparam int YO = 16, YM = 298, CKR = 409, CKGB = 100, CKGR = 208, CKB = 516;
`else
  localparam int YO = 0,  YM = 256, CKR = 359, CKGB = 88,  CKGR = 183, CKB = 454;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ycbcr422_rgb565_if bus();
  ycbcr422_rgb565 dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0]  cb, y0, cr, y1;
    logic [15:0] e0, e1;
  } vec_t;

  int errs = 0, checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int ph = 0, gcb = 0, gy0 = 0, gcr = 0;
  logic        ev [16];
  logic [15:0] ed [16];
  logic        ehs[16];
  logic        evs[16];
  logic [15:0] capq[$];

  function automatic int clip(int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic logic [15:0] ref_rgb(int y, int cb, int cr);
    int ys, r, g, b;
    ys = (y - YO) * YM;
    r = clip((ys + CKR * (cr - 128) + 128) >>> 8);
    g = clip((ys - CKGB * (cb - 128) - CKGR * (cr - 128) + 128) >>> 8);
    b = clip((ys + CKB * (cb - 128) + 128) >>> 8);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s (cycle %0d): got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: what the outputs must show 4 cycles after the inputs now on the bus.
  task automatic model_update();
    int a, d;
    a = (cyc + 4) % 16;
    d = int'(bus.pre_imgdata);
    if (rst) begin
      ph = 0;
      for (int k = 1; k <= 4; k++) begin
        ev[(cyc + k) % 16] = 1'b0; ed[(cyc + k) % 16] = '0;
        ehs[(cyc + k) % 16] = 1'b0; evs[(cyc + k) % 16] = 1'b0;
      end
    end else begin
      ev[a] = 1'b0;
      ed[a] = ed[(cyc + 3) % 16];
      ehs[a] = bus.pre_hs;
      evs[a] = bus.pre_vs;
      if (!bus.pre_hs) ph = 0;
      else if (bus.pre_clken) begin
        if (ph == 0) gcb = d;
        else if (ph == 1) gy0 = d;
        else if (ph == 2) begin gcr = d; ev[a] = 1'b1; ed[a] = ref_rgb(gy0, gcb, d); end
        else begin ev[a] = 1'b1; ed[a] = ref_rgb(d, gcb, gcr); end
        ph = (ph + 1) % 4;
      end
    end
  endtask

  task automatic step();
    int i;
    model_update();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (bus.post_clken) capq.push_back(bus.post_imgdata);
    if (chk_en) begin
      i = cyc % 16;
      chk("clken", 16'(bus.post_clken), 16'(ev[i]));
      chk("data",  bus.post_imgdata,    ed[i]);
      chk("hs",    16'(bus.post_hs),    16'(ehs[i]));
      chk("vs",    16'(bus.post_vs),    16'(evs[i]));
    end
  endtask

  task automatic put(logic [7:0] d, logic ce, logic hs, logic vs);
    bus.pre_imgdata = d; bus.pre_clken = ce; bus.pre_hs = hs; bus.pre_vs = vs;
    step();
  endtask

  vec_t tbl[4];

  initial begin
    logic hs_r, vs_r;
    logic [15:0] e_a, e_b, e_c;
    for (int k = 0; k < 16; k++) begin ev[k] = 0; ed[k] = '0; ehs[k] = 0; evs[k] = 0; end
`ifdef YCBCR_LIMITED_RANGE_EN
    tbl[0] = '{8'd128, 8'd128, 8'd128, 8'd255, 16'h8410, 16'hFFFF};
    tbl[1] = '{8'd128, 8'd76,  8'd255, 8'd76,  16'hF808, 16'hF808};
    tbl[2] = '{8'd128, 8'd16,  8'd128, 8'd16,  16'h0000, 16'h0000};
    tbl[3] = '{8'd0,   8'd0,   8'd0,   8'd0,   16'h0420, 16'h0420};
`else
    tbl[0] = '{8'd128, 8'd128, 8'd128, 8'd255, 16'h8410, 16'hFFFF};
    tbl[1] = '{8'd128, 8'd76,  8'd255, 8'd76,  16'hF809, 16'hF809};
    tbl[2] = '{8'd128, 8'd16,  8'd128, 8'd16,  16'h1082, 16'h1082};
    tbl[3] = '{8'd0,   8'd0,   8'd0,   8'd0,   16'h0440, 16'h0440};
`endif

    rst = 1'b1;
    for (int k = 0; k < 3; k++) put(8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_clken", 16'(bus.post_clken), 16'd0);
    chk("rst_data",  bus.post_imgdata,    16'd0);
    chk("rst_hs",    16'(bus.post_hs),    16'd0);
    chk("rst_vs",    16'(bus.post_vs),    16'd0);

    // Table: one UYVY group per entry, back-to-back bytes.
    for (int v = 0; v < 4; v++) begin
      capq.delete();
      put(tbl[v].cb, 1'b1, 1'b1, 1'b0);
      put(tbl[v].y0, 1'b1, 1'b1, 1'b0);
      put(tbl[v].cr, 1'b1, 1'b1, 1'b0);
      put(tbl[v].y1, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) put(8'h00, 1'b0, 1'b0, 1'b0);
      chk("tbl_count", 16'(capq.size()), 16'd2);
      if (capq.size() == 2) begin
        chk("tbl_px0", capq[0], tbl[v].e0);
        chk("tbl_px1", capq[1], tbl[v].e1);
      end
    end

    // Line of 6 bytes ends mid-group; next line must restart on its own Cb.
    capq.delete();
    put(8'd128, 1, 1, 0); put(8'd128, 1, 1, 0); put(8'd128, 1, 1, 0);
    put(8'd255, 1, 1, 0); put(8'd200, 1, 1, 0); put(8'd100, 1, 1, 0);
    for (int k = 0; k < 3; k++) put(8'h00, 0, 0, 0);
    put(8'd60, 1, 1, 0); put(8'd90, 1, 1, 0); put(8'd128, 1, 1, 0);
    for (int k = 0; k < 6; k++) put(8'h00, 0, 0, 0);
    e_a = ref_rgb(128, 128, 128); e_b = ref_rgb(255, 128, 128); e_c = ref_rgb(90, 60, 128);
    chk("line_count", 16'(capq.size()), 16'd3);
    if (capq.size() == 3) begin
      chk("line_px0", capq[0], e_a);
      chk("line_px1", capq[1], e_b);
      chk("line2_px0", capq[2], e_c);
    end

    // clken while hs is low must be ignored; vs keeps toggling through.
    capq.delete();
    for (int k = 0; k < 10; k++) put(8'($urandom), 1'b1, 1'b0, 1'((k % 3) == 0));
    for (int k = 0; k < 5; k++) put(8'h00, 0, 0, 0);
    chk("gated_count", 16'(capq.size()), 16'd0);

    // Reset right after a Cr byte drops that pixel and returns the phase to Cb.
    capq.delete();
    put(8'd128, 1, 1, 0); put(8'd50, 1, 1, 0); put(8'd200, 1, 1, 0);
    rst = 1'b1;
    put(8'h00, 0, 1, 0);
    rst = 1'b0;
    chk("midrst_clken", 16'(bus.post_clken), 16'd0);
    chk("midrst_data",  bus.post_imgdata,    16'd0);
    chk("midrst_hs",    16'(bus.post_hs),    16'd0);
    put(8'd128, 1, 1, 0); put(8'd200, 1, 1, 0); put(8'd128, 1, 1, 0);
    for (int k = 0; k < 6; k++) put(8'h00, 0, 0, 0);
    chk("midrst_count", 16'(capq.size()), 16'd1);
    if (capq.size() == 1) chk("midrst_px", capq[0], ref_rgb(200, 128, 128));

    // Random stream with line gaps, frame toggles and occasional resets.
    hs_r = 1'b1; vs_r = 1'b0;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 39) == 0) hs_r = ~hs_r;
      if ($urandom_range(0, 99) == 0) vs_r = ~vs_r;
      rst = ($urandom_range(0, 299) == 0);
      put(8'($urandom), 1'($urandom_range(0, 9) < 7), hs_r, vs_r);
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) put(8'h00, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
